result_bcd_converter: RTL and testbench

RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

---
 rtl/result_bcd_converter.sv | 101 ++++++++++
 tb/tb_result_bcd_converter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Signed 8-bit result word to sign + 3-digit BCD converter.
// The magnitude is converted with one shift-and-add-3 (double-dabble) iteration per clock.
module result_bcd_converter (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [19:0] dd;
    logic [19:0] dd_adj;
    logic [19:0] dd_step;
    logic [2:0]  iter;
    logic        sign_cap;
    logic        last;
    logic [7:0]  mag;

    assign last = (iter == 3'd7);
    // -128 negates to 8'h80, which is exactly the unsigned magnitude 128
    assign mag  = value[7] ? (~value + 8'd1) : value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dd_adj = dd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (dd_adj[8 + 4*i +: 4] >= 4'd5) begin
                dd_adj[8 + 4*i +: 4] = dd_adj[8 + 4*i +: 4] + 4'd3;
            end
        end
        dd_step = dd_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dd           <= '0;
            iter         <= '0;
            sign_cap     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sign         <= 1'b0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_cap <= value[7];
                        dd       <= {12'd0, mag};
                        iter     <= '0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    dd   <= dd_step;
                    iter <= iter + 3'd1;
                    if (last) begin
                        bcd_hundreds <= dd_step[19:16];
                        bcd_tens     <= dd_step[15:12];
                        bcd_ones     <= dd_step[11:8];
                        sign         <= sign_cap;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_result_bcd_converter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    int total = 0;
    int bad   = 0;

    result_bcd_converter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .value        (value),
        .busy         (busy),
        .done         (done),
        .sign         (sign),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a countdown of remaining edges and a decimal result from plain arithmetic.
    int         m_remain = 0;
    int         m_pend   = 0;
    logic       m_busy   = 1'b0;
    logic       m_done   = 1'b0;
    logic       m_sign   = 1'b0;
    logic [3:0] m_h      = '0;
    logic [3:0] m_t      = '0;
    logic [3:0] m_o      = '0;
    logic       m_valid  = 1'b0;

    always @(posedge clk) begin
        int mag;
        m_valid = 1'b1;
        m_done  = 1'b0;
        if (rst) begin
            m_remain = 0;
            m_sign   = 1'b0;
            m_h      = '0;
            m_t      = '0;
            m_o      = '0;
        end else if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
                mag    = (m_pend < 0) ? -m_pend : m_pend;
                m_done = 1'b1;
                m_sign = (m_pend < 0);
                m_h    = 4'(mag / 100);
                m_t    = 4'((mag / 10) % 10);
                m_o    = 4'(mag % 10);
            end
        end else if (start) begin
            m_remain = 8;
            m_pend   = int'($signed(value));
        end
        m_busy = (m_remain > 0);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if ({busy, done, sign, bcd_hundreds, bcd_tens, bcd_ones} !==
                {m_busy, m_done, m_sign, m_h, m_t, m_o}) begin
                bad++;
                $display("FAIL model t=%0t got busy=%b done=%b sign=%b %0d/%0d/%0d expected busy=%b done=%b sign=%b %0d/%0d/%0d",
                         $time, busy, done, sign, bcd_hundreds, bcd_tens, bcd_ones,
                         m_busy, m_done, m_sign, m_h, m_t, m_o);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input int s, input int h, input int t, input int o);
        check({name, "_sign"}, int'(sign), s);
        check({name, "_digits"}, int'({bcd_hundreds, bcd_tens, bcd_ones}), (h << 8) | (t << 4) | o);
    endtask

    // Called on a negedge; returns at the negedge where done is seen (or after a bounded wait).
    task automatic run(input logic [7:0] v, output int lat, output int busy_cnt);
        start    = 1'b1;
        value    = v;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) break;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for done value=%h", v);
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int n;
        int held_bad;

        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check_result("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // +127: done 8 edges after the accepting edge, busy for 8 cycles
        run(8'h7F, lat, bcnt);
        check("lat_7f", lat - 1, 8);
        check("busy_cycles_7f", bcnt, 8);
        check_result("res_7f", 0, 1, 2, 7);
        @(negedge clk);
        check("done_pulse_width", int'(done), 0);
        check_result("held_7f", 0, 1, 2, 7);

        run(8'h80, lat, bcnt);
        check_result("res_80", 1, 1, 2, 8);
        run(8'hFF, lat, bcnt);
        check_result("res_ff", 1, 0, 0, 1);
        run(8'h00, lat, bcnt);
        check_result("res_00", 0, 0, 0, 0);
        @(negedge clk);

        // Start during SHIFT is ignored, and the changed value does not leak in
        start = 1'b1; value = 8'h05;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; value = 8'h63;
        @(negedge clk); start = 1'b0;
        lat = 4;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("lat_05", lat - 1, 8);
        check_result("res_05", 0, 0, 0, 5);
        count_dones(12, n);
        check("no_second_done", n, 0);

        // Reset on the 4th SHIFT edge aborts the conversion
        start = 1'b1; value = 8'h40;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check_result("abort", 0, 0, 0, 0);
        count_dones(12, n);
        check("abort_no_done", n, 0);
        run(8'hF6, lat, bcnt);
        check("lat_f6", lat - 1, 8);
        check_result("res_f6", 1, 0, 1, 0);
        @(negedge clk);

        // Back-to-back: second start sampled on the edge where done is high
        run(8'h19, lat, bcnt);
        check_result("res_19", 0, 0, 2, 5);
        start = 1'b1; value = 8'hE7;
        n = 0;
        held_bad = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done) break;
            if ({sign, bcd_hundreds, bcd_tens, bcd_ones} !== {1'b0, 4'd0, 4'd2, 4'd5}) held_bad++;
        end
        check("b2b_done_spacing", n, 9);
        check("b2b_held_first", held_bad, 0);
        check_result("res_e7", 1, 0, 2, 5);
        @(negedge clk);

        for (int i = 0; i < 256; i++) begin
            run(i[7:0], lat, bcnt);
            check("decimal_nibbles", int'(bcd_hundreds <= 4'd1 && bcd_tens <= 4'd9 && bcd_ones <= 4'd9), 1);
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
